mandelbrot_pixel_sequencer: RTL and testbench
=============================================

# mandelbrot_pixel_sequencer

Raster sequencer that sits directly upstream of the Mandelbrot iteration core. On a frame request it walks a width×height pixel grid and computes each pixel's Q8.24 complex coordinate c = x0 + i·y0 by fixed-point stepping. It issues one job at a time to the core, waits for the core's iteration count, and emits that count as a pixel on a valid/ready stream towards the colour-mapping stage.

## Interface
- INTEGER_BITS, 8, integer bits of coordinate format
- FRACTIONAL_BITS, 24, fractional bits of coordinate format
- MAX_ITER_WIDTH, 16, iteration count width
- COORD_WIDTH, 11, pixel column/row counter width (max 2047×2047)

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- frame_start_i  in  1  start a frame; sampled only in IDLE
- x_min_i  in  DATA_WIDTH  signed Q, real part of column 0
- y_max_i  in  DATA_WIDTH  signed Q, imaginary part of row 0
- step_i  in  DATA_WIDTH  signed Q, pixel pitch (both axes)
- width_i, height_i  in  COORD_WIDTH  frame size in pixels
- max_iter_i  in  MAX_ITER_WIDTH  iteration limit
- core_start_o  out  1  job start pulse to core
- core_x0_o, core_y0_o  out  DATA_WIDTH  coordinate to core
- core_max_iter_o  out  MAX_ITER_WIDTH  latched limit to core
- core_done_i  in  1  core done (level, cleared by core on next start)
- core_iter_i  in  MAX_ITER_WIDTH  core iteration result
- pix_valid_o  out  1  pixel valid
- pix_ready_i  in  1  downstream ready
- pix_iter_o  out  MAX_ITER_WIDTH  pixel iteration count
- pix_sof_o  out  1  first pixel of frame
- pix_eol_o  out  1  last pixel of row
- busy_o  out  1  frame in progress
- frame_done_o  out  1  one-cycle pulse, frame complete

DATA_WIDTH = INTEGER_BITS + FRACTIONAL_BITS.

## Operation
- States: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE: on frame_start_i, latch x_min, y_max, step, width, height, max_iter; x0←x_min, y0←y_max, col←0, row←0. If width=0 or height=0: stay IDLE, pulse frame_done_o next cycle, emit no pixels. Else go to ISSUE.
- ISSUE: core_start_o=1 for exactly this cycle; next state WAIT.
- WAIT: ignore core_done_i in first WAIT cycle? No — core clears done at the start edge, so core_done_i is valid in every WAIT cycle. On core_done_i=1, capture core_iter_i into pix_iter_o; go to OUTPUT.
- OUTPUT: pix_valid_o=1; pix_iter_o, pix_sof_o, pix_eol_o stable until accepted (valid & ready). On accept:
  - col<width-1: col+1, x0←x0+step, go to ISSUE.
  - col=width-1, row<height-1: col←0, row+1, x0←x_min, y0←y0−step, go to ISSUE.
  - last pixel: go to IDLE, pulse frame_done_o.
- core_x0_o, core_y0_o, core_max_iter_o held stable from ISSUE through OUTPUT (core reads them every iteration).
- Coordinate adds/subtracts are DATA_WIDTH two's-complement, wrap modulo 2^DATA_WIDTH, no saturation.
- pix_sof_o = (col=0 & row=0); pix_eol_o = (col=width-1); both qualified by pix_valid_o (0 otherwise).
- frame_start_i while busy_o=1 ignored. Input config changes after latch have no effect on the current frame.
- busy_o=1 in ISSUE, WAIT, OUTPUT.

## Timing
- Reset (async): state IDLE; all outputs 0, including core_x0_o, core_y0_o, core_max_iter_o, pix_iter_o. Reset mid-frame aborts frame; no frame_done_o.
- frame_start_i in cycle T → core_start_o in T+1, WAIT from T+2.
- core_done_i in cycle W → pix_valid_o from W+1.
- Accept in cycle A → next core_start_o in A+1, or frame_done_o=1 and busy_o=0 in A+1.
- Minimum per-pixel period: 4 cycles (ISSUE, WAIT≥2 with core latency, OUTPUT with ready=1).
- Zero-size frame: frame_start_i in T → frame_done_o in T+1, busy_o stays 0.

## Structure
- Package mandelbrot_pkg: DATA_WIDTH derivation, state enum type, Q-format constant ONE = 1<<FRACTIONAL_BITS, coord/iter typedefs.
- Sub-module mandelbrot_coord_gen: col/row counters, x0/y0 accumulators, last-column/last-pixel flags; controlled by load/advance strobes from the FSM.

## Test plan
- x_min=0xFE000000 (−2.0), y_max=0x01000000 (1.0), step=0x00800000 (0.5), 3×2, core model → core_x0/y0 sequence (−2,1),(−1.5,1),(−1,1),(−2,0.5),(−1.5,0.5),(−1,0.5); sof on pixel 0, eol on pixels 2 and 5, frame_done once.
- Core model returns iter=7 after 2 cycles, ready tied 1 → core_start_o every 4 cycles, pix_iter_o=7 each pixel.
- pix_ready_i low for 5 cycles while valid → pix_iter_o/sof/eol stable, no new core_start_o, pixel accepted exactly once.
- width=0, height=4 → frame_done_o pulse at T+1, no core_start_o, no pix_valid_o.
- rst_i asserted during WAIT of pixel 3 → all outputs 0 immediately; new frame_start_i restarts at col 0 with sof.
- frame_start_i re-asserted mid-frame and x_min_i changed → ignored; frame completes with original coordinates.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot pixel sequencer.
package mandelbrot_pkg;

    localparam int unsigned INTEGER_BITS    = 8;
    localparam int unsigned FRACTIONAL_BITS = 24;
    localparam int unsigned DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS;
    localparam int unsigned MAX_ITER_WIDTH  = 16;
    localparam int unsigned COORD_WIDTH     = 11;

    // 1.0 in the signed Q(INTEGER_BITS).(FRACTIONAL_BITS) coordinate format
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << FRACTIONAL_BITS;

    typedef logic [DATA_WIDTH-1:0]     data_t;
    typedef logic [COORD_WIDTH-1:0]    coord_t;
    typedef logic [MAX_ITER_WIDTH-1:0] iter_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StOutput
    } state_e;

endpackage

// File: rtl/mandelbrot_coord_gen.sv
// Raster position and complex-coordinate generator. Holds the frame geometry
// latched at load and steps col/row and x0/y0 on each advance strobe.
module mandelbrot_coord_gen
    import mandelbrot_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned CoordWidth = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  logic [DataWidth-1:0]  x_min_i,
    input  logic [DataWidth-1:0]  y_max_i,
    input  logic [DataWidth-1:0]  step_i,
    input  logic [CoordWidth-1:0] width_i,
    input  logic [CoordWidth-1:0] height_i,
    output logic [DataWidth-1:0]  x0_o,
    output logic [DataWidth-1:0]  y0_o,
    output logic [CoordWidth-1:0] col_o,
    output logic [CoordWidth-1:0] row_o,
    output logic                  last_col_o,
    output logic                  last_pix_o
);

    logic [DataWidth-1:0]  r_x_min;
    logic [DataWidth-1:0]  r_step;
    logic [CoordWidth-1:0] r_width;
    logic [CoordWidth-1:0] r_height;
    logic [DataWidth-1:0]  r_x0;
    logic [DataWidth-1:0]  r_y0;
    logic [CoordWidth-1:0] r_col;
    logic [CoordWidth-1:0] r_row;
    logic                  w_last_col;
    logic                  w_last_row;

    // Flags are only meaningful for non-zero geometry; the FSM never advances otherwise
    assign w_last_col = (r_col == r_width - CoordWidth'(1));
    assign w_last_row = (r_row == r_height - CoordWidth'(1));

    // Geometry latch plus raster walk; coordinate arithmetic wraps modulo 2^DataWidth
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_x_min  <= '0;
            r_step   <= '0;
            r_width  <= '0;
            r_height <= '0;
            r_x0     <= '0;
            r_y0     <= '0;
            r_col    <= '0;
            r_row    <= '0;
        end else if (load_i) begin
            r_x_min  <= x_min_i;
            r_step   <= step_i;
            r_width  <= width_i;
            r_height <= height_i;
            r_x0     <= x_min_i;
            r_y0     <= y_max_i;
            r_col    <= '0;
            r_row    <= '0;
        end else if (advance_i) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + CoordWidth'(1);
                r_x0  <= r_x_min;
                r_y0  <= r_y0 - r_step;
            end else begin
                r_col <= r_col + CoordWidth'(1);
                r_x0  <= r_x0 + r_step;
            end
        end
    end

    assign x0_o       = r_x0;
    assign y0_o       = r_y0;
    assign col_o      = r_col;
    assign row_o      = r_row;
    assign last_col_o = w_last_col;
    assign last_pix_o = w_last_col & w_last_row;

endmodule

// File: rtl/mandelbrot_pixel_sequencer.sv
// Frame sequencer: walks the pixel grid, runs one iteration-core job per pixel
// and forwards each iteration count on a valid/ready pixel stream.
module mandelbrot_pixel_sequencer #(
    parameter int unsigned INTEGER_BITS    = 8,
    parameter int unsigned FRACTIONAL_BITS = 24,
    parameter int unsigned MAX_ITER_WIDTH  = 16,
    parameter int unsigned COORD_WIDTH     = 11
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    frame_start_i,
    input  logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] x_min_i,
    input  logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] y_max_i,
    input  logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] step_i,
    input  logic [COORD_WIDTH-1:0]                  width_i,
    input  logic [COORD_WIDTH-1:0]                  height_i,
    input  logic [MAX_ITER_WIDTH-1:0]               max_iter_i,
    output logic                                    core_start_o,
    output logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] core_x0_o,
    output logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] core_y0_o,
    output logic [MAX_ITER_WIDTH-1:0]               core_max_iter_o,
    input  logic                                    core_done_i,
    input  logic [MAX_ITER_WIDTH-1:0]               core_iter_i,
    output logic                                    pix_valid_o,
    input  logic                                    pix_ready_i,
    output logic [MAX_ITER_WIDTH-1:0]               pix_iter_o,
    output logic                                    pix_sof_o,
    output logic                                    pix_eol_o,
    output logic                                    busy_o,
    output logic                                    frame_done_o
);

    import mandelbrot_pkg::*;

    localparam int unsigned DW = INTEGER_BITS + FRACTIONAL_BITS;

    state_e                    r_state;
    state_e                    w_state_next;
    logic [MAX_ITER_WIDTH-1:0] r_max_iter;
    logic [MAX_ITER_WIDTH-1:0] r_pix_iter;
    logic                      r_frame_done;
    logic                      w_load;
    logic                      w_zero_size;
    logic                      w_accept;
    logic                      w_advance;
    logic [DW-1:0]             w_x0;
    logic [DW-1:0]             w_y0;
    logic [COORD_WIDTH-1:0]    w_col;
    logic [COORD_WIDTH-1:0]    w_row;
    logic                      w_last_col;
    logic                      w_last_pix;

    // Config is latched on every accepted start, including zero-size frames
    assign w_load      = (r_state == StIdle) & frame_start_i;
    assign w_zero_size = (width_i == '0) | (height_i == '0);
    assign w_accept    = pix_valid_o & pix_ready_i;
    // The final accept leaves the position alone so core inputs stay put in idle
    assign w_advance   = w_accept & ~w_last_pix;

    mandelbrot_coord_gen #(
        .DataWidth  (DW),
        .CoordWidth (COORD_WIDTH)
    ) u_coord_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_load),
        .advance_i  (w_advance),
        .x_min_i    (x_min_i),
        .y_max_i    (y_max_i),
        .step_i     (step_i),
        .width_i    (width_i),
        .height_i   (height_i),
        .x0_o       (w_x0),
        .y0_o       (w_y0),
        .col_o      (w_col),
        .row_o      (w_row),
        .last_col_o (w_last_col),
        .last_pix_o (w_last_pix)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (frame_start_i && !w_zero_size) begin
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                w_state_next = StWait;
            end
            StWait: begin
                // Core drops done on the start edge, so done here is always fresh
                if (core_done_i) begin
                    w_state_next = StOutput;
                end
            end
            StOutput: begin
                if (w_accept) begin
                    w_state_next = w_last_pix ? StIdle : StIssue;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        core_start_o = (r_state == StIssue);
        pix_valid_o  = (r_state == StOutput);
        busy_o       = (r_state != StIdle);
    end

    // Latched iteration limit, captured pixel result and frame-complete pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_max_iter   <= '0;
            r_pix_iter   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_load) begin
                r_max_iter <= max_iter_i;
            end
            if ((r_state == StWait) && core_done_i) begin
                r_pix_iter <= core_iter_i;
            end
            r_frame_done <= (w_load & w_zero_size) | (w_accept & w_last_pix);
        end
    end

    assign core_x0_o       = w_x0;
    assign core_y0_o       = w_y0;
    assign core_max_iter_o = r_max_iter;
    assign pix_iter_o      = r_pix_iter;
    assign pix_sof_o       = pix_valid_o & (w_col == '0) & (w_row == '0);
    assign pix_eol_o       = pix_valid_o & w_last_col;
    assign frame_done_o    = r_frame_done;

endmodule

// File: tb/tb_mandelbrot_pixel_sequencer.sv
// Directed bench for mandelbrot_pixel_sequencer with a simple iteration-core
// model and a queue scoreboard of expected jobs and pixels.
module tb_mandelbrot_pixel_sequencer;

    import mandelbrot_pkg::*;

    logic   clk_i = 1'b0;
    logic   rst_i;
    logic   frame_start_i;
    data_t  x_min_i, y_max_i, step_i;
    coord_t width_i, height_i;
    iter_t  max_iter_i;
    logic   core_start_o;
    data_t  core_x0_o, core_y0_o;
    iter_t  core_max_iter_o;
    logic   core_done_i;
    iter_t  core_iter_i;
    logic   pix_valid_o, pix_ready_i;
    iter_t  pix_iter_o;
    logic   pix_sof_o, pix_eol_o, busy_o, frame_done_o;

    mandelbrot_pixel_sequencer #(
        .INTEGER_BITS    (INTEGER_BITS),
        .FRACTIONAL_BITS (FRACTIONAL_BITS),
        .MAX_ITER_WIDTH  (MAX_ITER_WIDTH),
        .COORD_WIDTH     (COORD_WIDTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .frame_start_i   (frame_start_i),
        .x_min_i         (x_min_i),
        .y_max_i         (y_max_i),
        .step_i          (step_i),
        .width_i         (width_i),
        .height_i        (height_i),
        .max_iter_i      (max_iter_i),
        .core_start_o    (core_start_o),
        .core_x0_o       (core_x0_o),
        .core_y0_o       (core_y0_o),
        .core_max_iter_o (core_max_iter_o),
        .core_done_i     (core_done_i),
        .core_iter_i     (core_iter_i),
        .pix_valid_o     (pix_valid_o),
        .pix_ready_i     (pix_ready_i),
        .pix_iter_o      (pix_iter_o),
        .pix_sof_o       (pix_sof_o),
        .pix_eol_o       (pix_eol_o),
        .busy_o          (busy_o),
        .frame_done_o    (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Core model: done clears on the start edge and rises two cycles later
    logic [1:0] core_cnt;
    iter_t      core_iter_val;
    assign core_iter_i = core_iter_val;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            core_done_i <= 1'b0;
            core_cnt    <= 2'd0;
        end else if (core_start_o) begin
            core_done_i <= 1'b0;
            core_cnt    <= 2'd1;
        end else if (core_cnt != 2'd0) begin
            core_cnt <= core_cnt - 2'd1;
            if (core_cnt == 2'd1) core_done_i <= 1'b1;
        end
    end

    typedef struct {
        data_t x;
        data_t y;
        iter_t mi;
    } job_exp_t;

    typedef struct {
        data_t x;
        data_t y;
        iter_t it;
        logic  sof;
        logic  eol;
    } pix_exp_t;

    job_exp_t q_job[$];
    pix_exp_t q_pix[$];
    job_exp_t je;
    pix_exp_t pe;
    int       start_cyc[$];
    int       n_checks = 0, n_pass = 0, n_fail = 0;
    int       n_starts = 0, n_done = 0, n_valid = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: every core job and every accepted pixel is checked against the queues
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (pix_valid_o) n_valid++;
            if (core_start_o) begin
                n_starts++;
                start_cyc.push_back(cyc);
                if (q_job.size() == 0) begin
                    chk("unexpected_core_start", 32'(core_start_o), 32'(0));
                end else begin
                    je = q_job.pop_front();
                    chk("core_x0", core_x0_o, je.x);
                    chk("core_y0", core_y0_o, je.y);
                    chk("core_max_iter", 32'(core_max_iter_o), 32'(je.mi));
                end
            end
            if (pix_valid_o && pix_ready_i) begin
                if (q_pix.size() == 0) begin
                    chk("unexpected_pixel", 32'(pix_valid_o), 32'(0));
                end else begin
                    pe = q_pix.pop_front();
                    chk("pix_iter", 32'(pix_iter_o), 32'(pe.it));
                    chk("pix_sof", 32'(pix_sof_o), 32'(pe.sof));
                    chk("pix_eol", 32'(pix_eol_o), 32'(pe.eol));
                    chk("x0_held_at_output", core_x0_o, pe.x);
                    chk("y0_held_at_output", core_y0_o, pe.y);
                end
            end
            if (frame_done_o) begin
                n_done++;
                chk("busy_low_at_done", 32'(busy_o), 32'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cfg(input data_t xm, input data_t ym, input data_t st,
                           input int w, input int h, input int mi);
        x_min_i    = xm;
        y_max_i    = ym;
        step_i     = st;
        width_i    = coord_t'(w);
        height_i   = coord_t'(h);
        max_iter_i = iter_t'(mi);
    endtask

    // Expected coordinates by direct multiplication, not accumulation
    task automatic push_frame(input data_t xm, input data_t ym, input data_t st,
                              input int w, input int h, input int mi, input int it);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin : g_px
                job_exp_t j;
                pix_exp_t p;
                j.x  = xm + data_t'(c) * st;
                j.y  = ym - data_t'(r) * st;
                j.mi = iter_t'(mi);
                q_job.push_back(j);
                p.x   = j.x;
                p.y   = j.y;
                p.it  = iter_t'(it);
                p.sof = (r == 0) && (c == 0);
                p.eol = (c == w - 1);
                q_pix.push_back(p);
            end
        end
    endtask

    task automatic start_frame();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (n_done >= target) break;
            tick();
        end
        chk(tag, n_done, target);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_core_start"}, 32'(core_start_o), 32'(0));
        chk({tag, "_core_x0"}, core_x0_o, 32'(0));
        chk({tag, "_core_y0"}, core_y0_o, 32'(0));
        chk({tag, "_core_max_iter"}, 32'(core_max_iter_o), 32'(0));
        chk({tag, "_pix_valid"}, 32'(pix_valid_o), 32'(0));
        chk({tag, "_pix_iter"}, 32'(pix_iter_o), 32'(0));
        chk({tag, "_sof_eol"}, 32'({pix_sof_o, pix_eol_o}), 32'(0));
        chk({tag, "_busy"}, 32'(busy_o), 32'(0));
        chk({tag, "_frame_done"}, 32'(frame_done_o), 32'(0));
    endtask

    data_t xm_a, ym_a, st_a;
    int    s_starts, s_done, s_valid;
    logic  seen;

    initial begin
        rst_i         = 1'b1;
        frame_start_i = 1'b0;
        pix_ready_i   = 1'b1;
        core_iter_val = '0;
        set_cfg('0, '0, '0, 0, 0, 0);
        repeat (2) @(negedge clk_i);
        chk_all_zero("reset");
        tick();
        rst_i = 1'b0;
        tick();

        // Frame A: 3x2 from (-2, 1) with pitch 0.5, core returns 7, ready held high
        xm_a = '0 - (ONE << 1);
        ym_a = ONE;
        st_a = ONE >> 1;
        core_iter_val = 16'd7;
        set_cfg(xm_a, ym_a, st_a, 3, 2, 100);
        push_frame(xm_a, ym_a, st_a, 3, 2, 100, 7);
        start_cyc.delete();
        start_frame();
        @(negedge clk_i);
        chk("start_latency", 32'(core_start_o), 32'(1));
        chk("busy_in_issue", 32'(busy_o), 32'(1));
        wait_done(1, "frameA_done");
        chk("frameA_job_count", start_cyc.size(), 6);
        for (int i = 1; i < start_cyc.size(); i++) begin
            chk("start_period", start_cyc[i] - start_cyc[i-1], 4);
        end
        chk("frameA_pixels_left", q_pix.size(), 0);
        repeat (4) tick();
        chk("frame_done_single_pulse", n_done, 1);

        // Stall: ready low for 5 cycles on the first pixel
        core_iter_val = 16'h0123;
        set_cfg(ONE, '0, ONE >> 2, 2, 2, 50);
        push_frame(ONE, '0, ONE >> 2, 2, 2, 50, 16'h0123);
        pix_ready_i = 1'b0;
        start_frame();
        for (int i = 0; i < 20; i++) begin
            if (pix_valid_o) break;
            tick();
        end
        chk("stall_valid_seen", 32'(pix_valid_o), 32'(1));
        s_starts = n_starts;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall_valid_held", 32'(pix_valid_o), 32'(1));
            chk("stall_iter_held", 32'(pix_iter_o), 32'h0123);
            chk("stall_sof_eol_held", 32'({pix_sof_o, pix_eol_o}), 32'b10);
            chk("stall_no_start", 32'(core_start_o), 32'(0));
        end
        chk("stall_start_count", n_starts, s_starts);
        tick();
        pix_ready_i = 1'b1;
        wait_done(2, "stall_frame_done");
        chk("stall_pixels_left", q_pix.size(), 0);

        // Zero-width frame: done pulse next cycle, nothing issued
        set_cfg(ONE, ONE, ONE, 0, 4, 9);
        s_starts = n_starts;
        s_valid  = n_valid;
        start_frame();
        @(negedge clk_i);
        chk("zero_done_pulse", 32'(frame_done_o), 32'(1));
        chk("zero_busy_low", 32'(busy_o), 32'(0));
        repeat (5) tick();
        chk("zero_no_start", n_starts, s_starts);
        chk("zero_no_valid", n_valid, s_valid);
        chk("zero_done_count", n_done, 3);

        // Reset during the WAIT of pixel 3 aborts the frame
        core_iter_val = 16'd9;
        set_cfg(xm_a, ym_a, st_a, 3, 2, 100);
        push_frame(xm_a, ym_a, st_a, 3, 2, 100, 9);
        s_starts = n_starts + 4;
        start_frame();
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (n_starts == s_starts) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("reached_pixel3_wait", 32'(seen), 32'(1));
        s_done = n_done;
        rst_i  = 1'b1;
        #1;
        chk_all_zero("midframe_reset");
        tick();
        tick();
        rst_i = 1'b0;
        q_job.delete();
        q_pix.delete();
        tick();
        chk("no_done_after_abort", n_done, s_done);
        push_frame(xm_a, ym_a, st_a, 3, 2, 100, 9);
        start_frame();
        wait_done(s_done + 1, "restart_frame_done");
        chk("restart_pixels_left", q_pix.size(), 0);

        // Restart requests and config changes mid-frame are ignored
        core_iter_val = 16'd5;
        set_cfg('0 - ONE, ONE >> 1, ONE >> 3, 3, 2, 77);
        push_frame('0 - ONE, ONE >> 1, ONE >> 3, 3, 2, 77, 5);
        s_done = n_done;
        start_frame();
        repeat (3) tick();
        set_cfg(ONE << 2, '0, ONE, 5, 5, 3);
        frame_start_i = 1'b1;
        repeat (4) tick();
        frame_start_i = 1'b0;
        wait_done(s_done + 1, "ignore_restart_done");
        chk("ignore_restart_pixels_left", q_pix.size(), 0);
        chk("ignore_restart_jobs_left", q_job.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
